// File: rtl/spi_frame_serializer_if.sv
// spi_frame_serializer_if: frame request handshake between the request queue and the serializer
interface spi_frame_serializer_if #(
    parameter int OPCODEW = 2,
    parameter int ADDRW   = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [OPCODEW-1:0] opcode;
    logic [ADDRW-1:0]   addr;
    modport master (output in_valid, opcode, addr, input in_ready);
    modport slave (input in_valid, opcode, addr, output in_ready);
endinterface

// File: rtl/spi_frame_serializer.sv
// spi_frame_serializer: FIFO-buffered {opcode,addr} SPI slave transmitter for any CPOL/CPHA, MSB or LSB first
module spi_frame_serializer #(
    parameter int ADDRW     = 8,
    parameter int OPCODEW   = 2,
    parameter int DEPTH     = 4,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_clk_i,
    input  logic                         n_cs_i,
    spi_frame_serializer_if.slave        req,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level_o,
    output logic                         miso_o,
    output logic                         miso_oe_o,
    output logic                         frame_done_o,
    output logic                         abort_o,
    output logic                         underrun_o
);
    localparam int FW = OPCODEW + ADDRW;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(FW + 1);
    localparam int LW = $clog2(DEPTH + 1);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_DRAIN} state_e;
    state_e          state_q, state_d;
    logic            sclk_s1_q, sclk_s2_q, sclk_prev_q, cs_s1_q, cs_s2_q;
    logic [FW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FW-1:0]   shreg_q, shreg_d, head;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            miso_q, miso_d, done_q, done_d, abort_q, abort_d, under_q, under_d;
    logic            cs_active, edge_det, samp, launch, full, empty, push, pop;

    function automatic logic first_bit(logic [FW-1:0] f);
        return LSB_FIRST ? f[0] : f[FW-1];
    endfunction

    function automatic logic [FW-1:0] advance(logic [FW-1:0] f);
        return LSB_FIRST ? f >> 1 : f << 1;
    endfunction

    assign cs_active    = ~cs_s2_q;
    assign edge_det     = sclk_s2_q != sclk_prev_q;
    assign samp         = edge_det && (sclk_s2_q ^ CPOL ^ CPHA);
    assign launch       = edge_det && !(sclk_s2_q ^ CPOL ^ CPHA);
    assign empty        = wr_ptr_q == rd_ptr_q;
    assign full         = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign push         = req.in_valid && !full;
    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign req.in_ready = !full;
    assign fifo_level_o = LW'(wr_ptr_q - rd_ptr_q);
    assign miso_o       = miso_q;
    assign miso_oe_o    = cs_active;
    assign frame_done_o = done_q;
    assign abort_o      = abort_q;
    assign underrun_o   = under_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {req.opcode, req.addr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1_q   <= CPOL;
            sclk_s2_q   <= CPOL;
            sclk_prev_q <= CPOL;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            sclk_s1_q   <= spi_clk_i;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            cs_s1_q     <= n_cs_i;
            cs_s2_q     <= cs_s1_q;
            wr_ptr_q    <= wr_ptr_q + PW'(push);
            rd_ptr_q    <= rd_ptr_q + PW'(pop);
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            under_q     <= under_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        miso_d  = miso_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        under_d = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                miso_d = 1'b0;
                if (cs_active) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!cs_active) begin
                    state_d = S_IDLE;
                end else if (!empty) begin
                    pop     = 1'b1;
                    cnt_d   = CW'(FW);
                    state_d = S_SHIFT;
                    shreg_d = CPHA ? head : advance(head);
                    miso_d  = CPHA ? miso_q : first_bit(head);
                end else if (samp) begin
                    under_d = 1'b1;
                    miso_d  = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            S_SHIFT: begin
                if (!cs_active) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else if (launch && (CPHA || cnt_q != CW'(FW))) begin
                    miso_d  = first_bit(shreg_q);
                    shreg_d = advance(shreg_q);
                end else if (samp) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_DRAIN: begin
                miso_d = 1'b0;
                if (!cs_active) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
